// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: pipelined main decoder with valid/ready intake.
// The decoded control bundle and its tag move through DEPTH stage registers
// under hazard-unit stall/flush control. An accepted illegal opcode raises a
// trap that blocks intake until acknowledged. Illegal accepts are counted with
// saturation. All outputs come straight from the last stage register.
module ctrl_decode_pipe #(
    parameter int OP_WIDTH      = 7,
    parameter int IMM_SRC_WIDTH = 3,
    parameter int ALU_OP_WIDTH  = 3,
    parameter int TAG_WIDTH     = 32,
    parameter int DEPTH         = 2,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_WIDTH-1:0]      op,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     trap_ack,
    output logic                     out_valid,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     RegWrite,
    output logic                     ALUSrc,
    output logic                     MemWrite,
    output logic                     Branch,
    output logic                     Jump,
    output logic [IMM_SRC_WIDTH-1:0] ImmSrc,
    output logic [ALU_OP_WIDTH-1:0]  ALUOp,
    output logic [1:0]               ResultSrc,
    output logic                     out_illegal,
    output logic                     trap,
    output logic [CNT_WIDTH-1:0]     illegal_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    typedef struct packed {
        logic                     valid;
        logic                     illegal;
        logic [TAG_WIDTH-1:0]     tag;
        logic                     reg_write;
        logic [IMM_SRC_WIDTH-1:0] imm_src;
        logic                     alu_src;
        logic                     mem_write;
        logic [1:0]               result_src;
        logic                     branch;
        logic [ALU_OP_WIDTH-1:0]  alu_op;
        logic                     jump;
    } entry_t;

    localparam entry_t BUBBLE = entry_t'({$bits(entry_t){1'b0}});
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Decode one opcode into a valid pipeline entry; unknown opcodes (including
    // any with bits set above bit 6) yield all-zero controls and illegal=1.
    function automatic entry_t decode_entry(input logic [OP_WIDTH-1:0]  opcode,
                                            input logic [TAG_WIDTH-1:0] tag);
        entry_t e;
        e       = BUBBLE;
        e.valid = 1'b1;
        e.tag   = tag;
        if ((opcode >> 3'd7) != {OP_WIDTH{1'b0}}) begin
            e.illegal = 1'b1;
        end else begin
            case (opcode[6:0])
                7'b0000011: begin // load
                    e.reg_write  = 1'b1;
                    e.alu_src    = 1'b1;
                    e.result_src = 2'b01;
                end
                7'b0100011: begin // store
                    e.imm_src   = IMM_SRC_WIDTH'(3'b001);
                    e.alu_src   = 1'b1;
                    e.mem_write = 1'b1;
                end
                7'b0110011: begin // R-type
                    e.reg_write = 1'b1;
                    e.alu_op    = ALU_OP_WIDTH'(3'b010);
                end
                7'b0010011: begin // I-type ALU
                    e.reg_write = 1'b1;
                    e.alu_src   = 1'b1;
                    e.alu_op    = ALU_OP_WIDTH'(3'b010);
                end
                7'b1100011: begin // branch
                    e.imm_src = IMM_SRC_WIDTH'(3'b010);
                    e.branch  = 1'b1;
                    e.alu_op  = ALU_OP_WIDTH'(3'b001);
                end
                7'b0010111: begin // auipc
                    e.reg_write  = 1'b1;
                    e.imm_src    = IMM_SRC_WIDTH'(3'b011);
                    e.alu_src    = 1'b1;
                    e.result_src = 2'b11;
                    e.alu_op     = ALU_OP_WIDTH'(3'b100);
                end
                7'b0110111: begin // lui
                    e.reg_write = 1'b1;
                    e.imm_src   = IMM_SRC_WIDTH'(3'b011);
                    e.alu_src   = 1'b1;
                    e.alu_op    = ALU_OP_WIDTH'(3'b100);
                end
                7'b1100111: begin // jalr
                    e.reg_write  = 1'b1;
                    e.alu_src    = 1'b1;
                    e.result_src = 2'b10;
                    e.jump       = 1'b1;
                end
                7'b1101111: begin // jal
                    e.reg_write  = 1'b1;
                    e.imm_src    = IMM_SRC_WIDTH'(3'b100);
                    e.result_src = 2'b10;
                    e.jump       = 1'b1;
                end
                default: begin
                    e.illegal = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    state_e               state_q;
    logic                 trap_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    entry_t               stage_q [DEPTH];
    entry_t               stage_d [DEPTH];
    entry_t               dec_s;
    logic                 accept_s;
    logic                 ill_accept_s;

    assign in_ready     = (state_q == ST_RUN) && !stall && !flush;
    assign accept_s     = in_valid && in_ready;
    assign dec_s        = decode_entry(op, in_tag);
    assign ill_accept_s = accept_s && dec_s.illegal;

    // Next contents of every stage: flush empties, stall holds, else shift in.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = BUBBLE;
            end
        end else if (!stall) begin
            stage_d[0] = accept_s ? dec_s : BUBBLE;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end else begin
            stage_d[0] = stage_q[0];
        end
    end

    // Stage registers; reset fills the pipe with bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= BUBBLE;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Saturating increment of the illegal-accept count.
    always_comb begin
        count_d = count_q;
        if (ill_accept_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // RUN/TRAP state machine with registered trap flag and event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            trap_q  <= 1'b0;
            count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
            case (state_q)
                ST_RUN: begin
                    if (ill_accept_s) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        trap_q  <= 1'b0;
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        state_q <= ST_RUN;
                        trap_q  <= 1'b0;
                    end else begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid     = stage_q[DEPTH-1].valid;
    assign out_illegal   = stage_q[DEPTH-1].illegal;
    assign out_tag       = stage_q[DEPTH-1].tag;
    assign RegWrite      = stage_q[DEPTH-1].reg_write;
    assign ImmSrc        = stage_q[DEPTH-1].imm_src;
    assign ALUSrc        = stage_q[DEPTH-1].alu_src;
    assign MemWrite      = stage_q[DEPTH-1].mem_write;
    assign ResultSrc     = stage_q[DEPTH-1].result_src;
    assign Branch        = stage_q[DEPTH-1].branch;
    assign ALUOp         = stage_q[DEPTH-1].alu_op;
    assign Jump          = stage_q[DEPTH-1].jump;
    assign trap          = trap_q;
    assign illegal_count = count_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two instances (DEPTH=2/CNT_WIDTH=8 and
// DEPTH=3/CNT_WIDTH=2) share one stimulus stream and are compared each cycle
// against a slot-list model built from the decode table.
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  op = 7'd0;
    logic [31:0] in_tag = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        trap_ack = 1'b0;

    always #5 clk = ~clk;

    logic        rdy_a, ov_a, ill_a, rw_a, as_a, mw_a, br_a, jp_a, trap_a;
    logic [31:0] tag_a;
    logic [2:0]  imm_a, aop_a;
    logic [1:0]  rs_a;
    logic [7:0]  cnt_a;
    logic        rdy_b, ov_b, ill_b, rw_b, as_b, mw_b, br_b, jp_b, trap_b;
    logic [31:0] tag_b;
    logic [2:0]  imm_b, aop_b;
    logic [1:0]  rs_b;
    logic [1:0]  cnt_b;

    ctrl_decode_pipe #(.DEPTH(2), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .op(op),
        .in_tag(in_tag), .stall(stall), .flush(flush), .trap_ack(trap_ack),
        .out_valid(ov_a), .out_tag(tag_a), .RegWrite(rw_a), .ALUSrc(as_a),
        .MemWrite(mw_a), .Branch(br_a), .Jump(jp_a), .ImmSrc(imm_a), .ALUOp(aop_a),
        .ResultSrc(rs_a), .out_illegal(ill_a), .trap(trap_a), .illegal_count(cnt_a));

    ctrl_decode_pipe #(.DEPTH(3), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .op(op),
        .in_tag(in_tag), .stall(stall), .flush(flush), .trap_ack(trap_ack),
        .out_valid(ov_b), .out_tag(tag_b), .RegWrite(rw_b), .ALUSrc(as_b),
        .MemWrite(mw_b), .Branch(br_b), .Jump(jp_b), .ImmSrc(imm_b), .ALUOp(aop_b),
        .ResultSrc(rs_b), .out_illegal(ill_b), .trap(trap_b), .illegal_count(cnt_b));

    // {valid, illegal, tag[31:0], RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}
    wire [46:0] va = {ov_a, ill_a, tag_a, rw_a, imm_a, as_a, mw_a, rs_a, br_a, aop_a, jp_a};
    wire [46:0] vb = {ov_b, ill_b, tag_b, rw_b, imm_b, as_b, mw_b, rs_b, br_b, aop_b, jp_b};

    int nvec = 0;
    int nerr = 0;

    // model: per instance a list of slots, slot[depth-1] is what the outputs show
    logic [46:0] mp [2][4];
    int          mdepth [2] = '{2, 3};
    int          mmax   [2] = '{255, 3};
    int          mcnt   [2];
    bit          mtrap;

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b0010111, 7'b0110111, 7'b1100111,
                                  7'b1101111};

    // {illegal, controls in decode order}
    function automatic logic [13:0] mdec(input logic [6:0] o);
        case (o)
            7'b0000011: return {1'b0, 13'b1_000_1_0_01_0_000_0};
            7'b0100011: return {1'b0, 13'b0_001_1_1_00_0_000_0};
            7'b0110011: return {1'b0, 13'b1_000_0_0_00_0_010_0};
            7'b0010011: return {1'b0, 13'b1_000_1_0_00_0_010_0};
            7'b1100011: return {1'b0, 13'b0_010_0_0_00_1_001_0};
            7'b0010111: return {1'b0, 13'b1_011_1_0_11_0_100_0};
            7'b0110111: return {1'b0, 13'b1_011_1_0_00_0_100_0};
            7'b1100111: return {1'b0, 13'b1_000_1_0_10_0_000_1};
            7'b1101111: return {1'b0, 13'b1_100_0_0_10_0_000_1};
            default:    return {1'b1, 13'b0};
        endcase
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) mp[i][k] = 47'd0;
            mcnt[i] = 0;
        end
        mtrap = 1'b0;
    endtask

    // advance the model by one rising edge using the inputs currently driven
    task automatic mstep();
        bit          acc;
        logic [13:0] d;
        acc = in_valid && !mtrap && !stall && !flush;
        d   = mdec(op);
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                for (int k = 0; k < 4; k++) mp[i][k] = 47'd0;
            end else if (!stall) begin
                for (int k = 3; k > 0; k--) mp[i][k] = mp[i][k-1];
                mp[i][0] = acc ? {1'b1, d[13], in_tag, d[12:0]} : 47'd0;
            end
            if (acc && d[13] && mcnt[i] < mmax[i]) mcnt[i]++;
        end
        if (mtrap && trap_ack) mtrap = 1'b0;
        else if (acc && d[13]) mtrap = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_a",  {17'd0, va}, {17'd0, mp[0][1]});
        chk("trap_a", {63'd0, trap_a}, {63'd0, mtrap});
        chk("cnt_a",  {56'd0, cnt_a}, 64'(mcnt[0]));
        chk("out_b",  {17'd0, vb}, {17'd0, mp[1][2]});
        chk("trap_b", {63'd0, trap_b}, {63'd0, mtrap});
        chk("cnt_b",  {62'd0, cnt_b}, 64'(mcnt[1]));
    endtask

    // called just after a falling edge with inputs driven: check ready, clock once, check outputs
    task automatic apply();
        bit er;
        #1;
        er = !mtrap && !stall && !flush;
        chk("in_ready_a", {63'd0, rdy_a}, {63'd0, er});
        chk("in_ready_b", {63'd0, rdy_b}, {63'd0, er});
        mstep();
        @(negedge clk);
        check_all();
    endtask

    task automatic drv(input bit v, input logic [6:0] o, input logic [31:0] t,
                       input bit s, input bit f, input bit a);
        in_valid = v; op = o; in_tag = t; stall = s; flush = f; trap_ack = a;
    endtask

    initial begin
        mreset();
        // reset state
        #12;
        chk("rst_out",   {17'd0, va}, 64'd0);
        chk("rst_trap",  {63'd0, trap_a}, 64'd0);
        chk("rst_cnt",   {56'd0, cnt_a}, 64'd0);
        chk("rst_ready", {63'd0, rdy_a}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // lw then add back-to-back
        drv(1, 7'b0000011, 32'h100, 0, 0, 0); apply();
        drv(1, 7'b0110011, 32'h104, 0, 0, 0); apply();
        chk("lw_tag",  {32'd0, tag_a}, 64'h100);
        chk("lw_ctrl", {51'd0, va[12:0]}, {51'd0, 13'b1_000_1_0_01_0_000_0});
        chk("lw_vld",  {63'd0, ov_a}, 64'd1);
        drv(0, 7'd0, 32'd0, 0, 0, 0); apply();
        chk("add_tag",  {32'd0, tag_a}, 64'h104);
        chk("add_ctrl", {51'd0, va[12:0]}, {51'd0, 13'b1_000_0_0_00_0_010_0});
        chk("add_vld",  {63'd0, ov_a}, 64'd1);

        // jal held by a 3-cycle stall
        drv(1, 7'b1101111, 32'h200, 0, 0, 0); apply();
        for (int i = 0; i < 3; i++) begin
            drv(0, 7'd0, 32'd0, 1, 0, 0);
            #1 chk("stall_ready", {63'd0, rdy_a}, 64'd0);
            apply();
            chk("stall_frozen", {63'd0, ov_a}, 64'd0);
        end
        drv(0, 7'd0, 32'd0, 0, 0, 0); apply();
        chk("jal_rs",  {62'd0, rs_a}, 64'd2);
        chk("jal_j",   {63'd0, jp_a}, 64'd1);
        chk("jal_tag", {32'd0, tag_a}, 64'h200);

        // flush with two in flight, stall high and a new entry offered
        drv(1, 7'b0000011, 32'h400, 0, 0, 0); apply();
        drv(1, 7'b0110011, 32'h404, 0, 0, 0); apply();
        drv(1, 7'b0010011, 32'h408, 1, 1, 0); apply();
        chk("flush_out", {17'd0, va}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 7'd0, 32'd0, 0, 0, 0); apply();
            chk("flush_drop", {63'd0, ov_a}, 64'd0);
        end

        // illegal opcode and trap handshake
        drv(1, 7'b1111111, 32'h300, 0, 0, 0); apply();
        chk("ill_trap", {63'd0, trap_a}, 64'd1);
        chk("ill_cnt",  {56'd0, cnt_a}, 64'd1);
        drv(1, 7'b0110011, 32'h304, 0, 0, 0);
        #1 chk("ill_ready", {63'd0, rdy_a}, 64'd0);
        apply();
        chk("ill_out", {17'd0, va}, {17'd0, 1'b1, 1'b1, 32'h300, 13'd0});
        drv(0, 7'd0, 32'd0, 0, 0, 1); apply();
        chk("ack_trap", {63'd0, trap_a}, 64'd0);
        drv(0, 7'd0, 32'd0, 0, 0, 0);
        #1 chk("ack_ready", {63'd0, rdy_a}, 64'd1);
        apply();

        // five more illegal/ack pairs: 8-bit counter reaches 6, 2-bit one pins at 3
        for (int i = 0; i < 5; i++) begin
            drv(1, 7'b0000000, 32'h500 + i, 0, 0, 0); apply();
            drv(0, 7'd0, 32'd0, 0, 0, 1); apply();
        end
        chk("sat_cnt_a", {56'd0, cnt_a}, 64'd6);
        chk("sat_cnt_b", {62'd0, cnt_b}, 64'd3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [6:0] o;
            o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
            drv($urandom_range(0, 3) != 0, o, $urandom,
                $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
                mtrap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0));
            apply();
        end

        // asynchronous reset while trapped
        drv(1, 7'b1111111, 32'h600, 0, 0, 0); apply();
        drv(1, 7'b1101111, 32'h604, 0, 0, 0); apply();
        chk("pre_rst_trap", {63'd0, trap_a}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_a", {17'd0, va}, 64'd0);
        chk("arst_out_b", {17'd0, vb}, 64'd0);
        chk("arst_trap",  {63'd0, trap_a}, 64'd0);
        chk("arst_cnt",   {56'd0, cnt_a}, 64'd0);
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        drv(0, 7'd0, 32'd0, 0, 0, 0);
        #1 chk("post_rst_ready", {63'd0, rdy_a}, 64'd1);
        apply();
        drv(1, 7'b0110111, 32'h700, 0, 0, 0); apply();
        drv(0, 7'd0, 32'd0, 0, 0, 0); apply();
        chk("post_rst_lui", {17'd0, va}, {17'd0, 1'b1, 1'b0, 32'h700, 13'b1_011_1_0_00_0_100_0});
        apply();
        apply();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
